// File: rtl/systolic_result_packer.sv
// Packs a captured BN_NUM-element result vector into PACK_NUM-lane words and
// drains them through a register FIFO. Optional build macro: RESULT_PACKER_PARITY_EN.
module systolic_result_packer #(
  parameter int BN_NUM     = 10,
  parameter int BW_ACT     = 8,
  parameter int PACK_NUM   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       res_valid_in,
  input  logic signed [BW_ACT-1:0]   res_in [BN_NUM],
  output logic                       res_ready_out,
  output logic                       out_valid,
  output logic [PACK_NUM*BW_ACT-1:0] out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       drop_err,
  input  logic                       err_clr,
  output logic                       dbg_state
`ifdef RESULT_PACKER_PARITY_EN
  ,
  output logic [PACK_NUM-1:0]        out_parity
`endif
);

  localparam int NW    = (BN_NUM + PACK_NUM - 1) / PACK_NUM;
  localparam int IDX_W = $clog2(NW * PACK_NUM + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WW    = PACK_NUM * BW_ACT;

  typedef enum logic {S_IDLE = 1'b0, S_PACK = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [BW_ACT-1:0]  cap_q [BN_NUM];
  logic [IDX_W-1:0]   idx_q;
  logic [WW-1:0]      mem_data [FIFO_DEPTH];
  logic               mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               drop_q;

  logic               push, pop, last_word, drop;
  logic [WW-1:0]      push_data;

  // Handshake: a word transfers on every edge where out_valid && out_ready;
  // once out_valid is high it stays high with out_data/out_last unchanged
  // until that transfer happens.
  assign push      = (state_q == S_PACK) && (count_q < CNT_W'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign last_word = (idx_q == IDX_W'((NW - 1) * PACK_NUM));
  assign drop      = res_valid_in && !res_ready_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (res_valid_in) state_d = S_PACK;
      S_PACK:  if (push && last_word) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_ready_out = (state_q == S_IDLE);
    busy          = (state_q == S_PACK) || (count_q != '0);
    dbg_state     = state_q;
  end

  // Lane k takes element idx+k; lanes past the end of the vector stay zero.
  always_comb begin
    push_data = '0;
    for (int k = 0; k < PACK_NUM; k++) begin
      for (int e = 0; e < BN_NUM; e++) begin
        if (int'(idx_q) + k == e) push_data[k*BW_ACT +: BW_ACT] = cap_q[e];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      for (int i = 0; i < BN_NUM; i++) cap_q[i] <= '0;
    end else if (state_q == S_IDLE && res_valid_in) begin
      idx_q <= '0;
      for (int i = 0; i < BN_NUM; i++) cap_q[i] <= res_in[i];
    end else if (push) begin
      idx_q <= idx_q + IDX_W'(PACK_NUM);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr_q] <= push_data;
        mem_last[wr_ptr_q] <= last_word;
        wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef RESULT_PACKER_PARITY_EN
  logic [PACK_NUM-1:0] mem_par [FIFO_DEPTH];
  logic [PACK_NUM-1:0] push_par;

  always_comb begin
    push_par = '0;
    for (int k = 0; k < PACK_NUM; k++) push_par[k] = ^push_data[k*BW_ACT +: BW_ACT];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_par[i] <= '0;
    end else if (push) begin
      mem_par[wr_ptr_q] <= push_par;
    end
  end

  assign out_parity = mem_par[rd_ptr_q];
`endif

  // A drop in the same cycle as err_clr must not be lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     drop_q <= 1'b0;
    else if (drop)    drop_q <= 1'b1;
    else if (err_clr) drop_q <= 1'b0;
  end

  assign drop_err  = drop_q;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_data[rd_ptr_q];
  assign out_last  = mem_last[rd_ptr_q];

endmodule
